// File: rtl/router_pkg.sv
// Shared router definitions: transmitter FSM states, header field widths,
// the reserved destination code and the header byte packing helper.
package router_pkg;

   localparam int LEN_W  = 6;
   localparam int ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PARITY  = 3'd3,
      ST_GAP     = 3'd4
   } tx_state_e;

   // Header byte: length in the upper six bits, destination port in the lower two.
   function automatic logic [7:0] hdr_byte(input logic [LEN_W-1:0]  len,
                                           input logic [ADDR_W-1:0] dest);
      return {len, dest};
   endfunction

endpackage

// File: rtl/router_pkt_tx_fifo.sv
// Synchronous byte FIFO for the packet source payload buffer.
// Power-of-two depth; pointers wrap naturally. Push is ignored when full,
// pop is ignored when empty; push and pop together leave count unchanged.
module router_pkt_tx_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; reset flushes the buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers payload bytes and,
// per command, sends header, payload and parity onto pkt_valid/data_out.
// Optional build macro ROUTER_PKT_TX_ERR_INJ_EN adds the inj_err input, which
// flips parity bit 0 of the packet whose command it accompanied.
//
// state   | meaning
// IDLE    | waiting for a command; illegal commands are dropped here
// HEADER  | header byte on data_out, pkt_valid=1
// PAYLOAD | FIFO bytes on data_out, pkt_valid=1
// PARITY  | parity byte on data_out, pkt_valid=0
// GAP     | enforced idle spacing before the next command can be taken
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] cmd_dest,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              cmd_ready,
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
   input  logic              inj_err,
`endif
   input  logic              busy,
   input  logic              err,
   output logic              pkt_valid,
   output logic [7:0]        data_out,
   output logic              tx_done,
   output logic              cmd_err,
   output logic [7:0]        err_cnt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   tx_state_e         state;
   logic              run;
   logic [7:0]        parity;
   logic [LEN_W-1:0]  rem_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              inj_bit;

   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [7:0]        fifo_head;
   logic              fifo_push;
   logic              fifo_pop;
   logic              cmd_illegal;
   logic              cmd_fire;

   assign cmd_illegal = (cmd_dest == ADDR_INVALID) || (cmd_len == '0);
   // run is low through reset so both ready signals read 0 in the reset cycle.
   assign s_ready     = run && !fifo_full;
   assign cmd_ready   = run && !busy && (state == ST_IDLE) &&
                        (cmd_illegal || (fifo_count >= CNT_W'(cmd_len)));
   assign cmd_fire    = cmd_valid && cmd_ready;
   assign fifo_push   = s_valid && s_ready;
   // The next payload byte moves from the FIFO into data_out at the same edge
   // that retires the byte currently on the bus.
   assign fifo_pop    = !busy && ((state == ST_HEADER) ||
                                  ((state == ST_PAYLOAD) && (rem_cnt != LEN_W'(1))));

   router_pkt_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (s_data),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
   logic inj_q;

   // Injection request is captured with the command it belongs to.
   always_ff @(posedge clk) begin
      if (!rst)                                inj_q <= 1'b0;
      else if (cmd_fire && !cmd_illegal)       inj_q <= inj_err;
   end

   assign inj_bit = inj_q;
`else
   assign inj_bit = 1'b0;
`endif

   // Packet sequencing FSM with registered bus outputs; busy freezes everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         run       <= 1'b0;
         pkt_valid <= 1'b0;
         data_out  <= '0;
         tx_done   <= 1'b0;
         cmd_err   <= 1'b0;
         parity    <= '0;
         rem_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         run     <= 1'b1;
         tx_done <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  if (cmd_illegal) begin
                     cmd_err <= 1'b1;
                  end else begin
                     data_out  <= hdr_byte(cmd_len, cmd_dest);
                     pkt_valid <= 1'b1;
                     rem_cnt   <= cmd_len;
                     state     <= ST_HEADER;
                  end
               end
            end
            ST_HEADER: begin
               if (!busy) begin
                  parity   <= data_out;
                  data_out <= fifo_head;
                  state    <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (!busy) begin
                  if (rem_cnt == LEN_W'(1)) begin
                     parity    <= parity ^ data_out;
                     data_out  <= parity ^ data_out ^ {7'd0, inj_bit};
                     pkt_valid <= 1'b0;
                     state     <= ST_PARITY;
                  end else begin
                     parity   <= parity ^ data_out;
                     data_out <= fifo_head;
                     rem_cnt  <= rem_cnt - LEN_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  tx_done <= 1'b1;
                  // The IDLE accept cycle is itself one of the idle cycles,
                  // so GAP only covers the remaining GAP_CYCLES-1.
                  if (GAP_CYCLES > 1) begin
                     gap_cnt <= GAP_W'(GAP_CYCLES - 2);
                     state   <= ST_GAP;
                  end else begin
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (!busy) begin
                  if (gap_cnt == '0) state   <= ST_IDLE;
                  else               gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Router parity-error counter, saturating at 255.
   always_ff @(posedge clk) begin
      if (!rst)                          err_cnt <= '0;
      else if (err && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
   end

endmodule
